// File: rtl/serial_full_adder_unit.sv
// rtl/serial_full_adder_unit.sv - bit-serial adder/subtractor on one full-adder cell (optional SERIAL_ADDER_SUB_EN)
module serial_full_adder_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last_bit;
    logic             s;
    logic             c_next;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] load_b;
    logic             load_c;

    assign accept   = start && (state != S_RUN);
    assign last_bit = (cnt == LAST);

    // Full-adder cell: parity sum and majority carry on the current LSBs
    always_comb begin
        s      = a_sh[0] ^ b_sh[0] ^ c;
        c_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    end

    // New sum bit enters at the MSB so bit i lands at sum[i] after WIDTH shifts
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_next = s;
        end else begin : g_sum_wn
            assign sum_next = {s, sum[WIDTH-1:1]};
        end
    endgenerate

    // Operand B and carry seed for the accepting edge (subtract = add inverted B plus one)
    always_comb begin
        load_b = b;
        load_c = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            load_b = ~b;
            load_c = 1'b1;
        end
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start during RUN is ignored
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_bit) state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    // Datapath: load on accept, one bit per RUN cycle, flags captured on the last bit
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= load_b;
            c    <= load_c;
            cnt  <= '0;
        end else if (state == S_RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            c    <= c_next;
            cnt  <= cnt + CW'(1);
            sum  <= sum_next;
            if (last_bit) begin
                cout <= c_next;
                ovf  <= c ^ c_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_full_adder_unit.sv
// tb/tb_serial_full_adder_unit.sv - directed table-driven bench for serial_full_adder_unit
module tb_serial_full_adder_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub = 1'b0;
    logic         sub1 = 1'b0;
`endif
    logic [W-1:0] sum;
    logic         cout, ovf, busy, done;

    logic         start1 = 1'b0;
    logic         a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic         sum1, cout1, ovf1, busy1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_full_adder_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
    );

    serial_full_adder_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub1),
`endif
        .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Pulse start with the vector, check busy for W cycles, then the done cycle
    task automatic run_vec(input vec_t v, input string name);
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = v.sub;
`endif
        @(negedge clk);
        start = 1'b0;
        a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        for (int k = 0; k < W; k++) begin
            check({name, " busy"}, {63'd0, busy}, 64'd1);
            check({name, " no early done"}, {63'd0, done}, 64'd0);
            @(negedge clk);
        end
        check({name, " done"}, {63'd0, done}, 64'd1);
        check({name, " busy in done"}, {63'd0, busy}, 64'd0);
        check({name, " sum"}, {56'd0, sum}, {56'd0, v.exp_sum});
        check({name, " cout"}, {63'd0, cout}, {63'd0, v.exp_cout});
        check({name, " ovf"}, {63'd0, ovf}, {63'd0, v.exp_ovf});
        @(negedge clk);
        check({name, " done one cycle"}, {63'd0, done}, 64'd0);
        check({name, " sum held"}, {56'd0, sum}, {56'd0, v.exp_sum});
    endtask

    task automatic run_w1(input logic va, input logic vb, input logic vc,
                          input logic es, input logic ec, input logic eo, input string name);
        @(negedge clk);
        a1 = va; b1 = vb; cin1 = vc; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check({name, " busy"}, {63'd0, busy1}, 64'd1);
        @(negedge clk);
        check({name, " done"}, {63'd0, done1}, 64'd1);
        check({name, " sum"}, {63'd0, sum1}, {63'd0, es});
        check({name, " cout"}, {63'd0, cout1}, {63'd0, ec});
        check({name, " ovf"}, {63'd0, ovf1}, {63'd0, eo});
        @(negedge clk);
    endtask

    initial begin
        int waited;
        vecs.push_back('{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
        vecs.push_back('{8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0});
`endif

        // Reset with start asserted: reset must win
        start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset sum", {56'd0, sum}, 64'd0);
        check("reset cout", {63'd0, cout}, 64'd0);
        check("reset ovf", {63'd0, ovf}, 64'd0);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // start re-asserted throughout RUN is ignored; start held in done cycle chains
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            a = 8'h11 + 8'(k); b = 8'hE0 - 8'(k); cin = k[0];
            check("ignore busy", {63'd0, busy}, 64'd1);
        end
        @(negedge clk);
        check("ignore done", {63'd0, done}, 64'd1);
        check("ignore sum", {56'd0, sum}, 64'h96);
        check("ignore cout", {63'd0, cout}, 64'd0);
        check("ignore ovf", {63'd0, ovf}, 64'd1);
        a = 8'hFF; b = 8'h01; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("chain no gap", {63'd0, busy}, 64'd1);
        waited = 0;
        while (!done && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("chain latency", 64'(waited), 64'(W));
        check("chain sum", {56'd0, sum}, 64'h01);
        check("chain cout", {63'd0, cout}, 64'd1);
        check("chain ovf", {63'd0, ovf}, 64'd0);

        // Reset three cycles into RUN aborts the operation
        @(negedge clk);
        a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-abort busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort done", {63'd0, done}, 64'd0);
        check("abort sum", {56'd0, sum}, 64'd0);
        check("abort cout", {63'd0, cout}, 64'd0);
        check("abort ovf", {63'd0, ovf}, 64'd0);
        waited = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) waited++;
        end
        check("abort stays idle", 64'(waited), 64'd0);

        // WIDTH=1 instance
        run_w1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "w1 111");
        run_w1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "w1 110");
        run_w1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "w1 100");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_full_adder_unit.md
# serial_full_adder_unit

Parametrised bit-serial adder built around a single full-adder cell: parity sum (a^b^c) and majority carry (ab+ac+bc). It latches two WIDTH-bit operands on a start pulse and processes one bit per clock, LSB first, through a registered carry. It then reports sum, carry-out and signed overflow with a done pulse. It is the sequential, width-generic successor of the team's combinational 3-input parity/majority cells, for area-constrained datapaths.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled each rising edge; accepted only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- sub  input  1  subtract select; exists only when SERIAL_ADDER_SUB_EN is defined.
- sum  output  WIDTH  result register.
- cout  output  1  carry out of the MSB.
- ovf  output  1  two's-complement overflow: carry into MSB xor carry out of MSB.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN.
  - RUN: after WIDTH bit-cycles -> DONE.
  - DONE: start=1 -> RUN; otherwise -> IDLE.
- On the accepting edge:
  - Load the operand shift registers with a and b.
  - Load the carry flop with cin.
  - Clear the bit counter (width clog2(WIDTH+1)).
- Each RUN cycle:
  - s = a[0]^b[0]^c; c_next = a[0]&b[0] | a[0]&c | b[0]&c.
  - Shift s into sum from the MSB side, so after WIDTH shifts bit i sits at sum[i].
  - Shift the operands right by one; increment the counter.
- Final bit (counter = WIDTH-1):
  - cout <= c_next.
  - ovf <= c ^ c_next, where c is the carry into the MSB.
  - For WIDTH=1, that carry-in is cin.
- sum, cout and ovf hold their values from the done cycle until the next accepted start. Their values during RUN are unspecified to the bench and only checked at done.
- start while busy=1 is ignored: no restart, no queuing.
- Reset mid-operation aborts immediately: state IDLE, result discarded.

## Timing
- Reset value (one edge with rst=1): state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, carry flop=0, counter=0.
- rst has priority over start on the same edge.
- Start accepted at edge E0: busy=1 in the cycles after E0 through edge E(WIDTH).
- Bit i is computed at edge E(i+1).
- done=1 for exactly one cycle after edge E(WIDTH), with busy=0 in that cycle. Latency from start to done is WIDTH cycles.
- Back-to-back: start=1 during the done cycle is accepted at that edge. Throughput is one result per WIDTH cycles, with no idle gap.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - The sub port exists and is sampled on the accepting edge.
  - With sub=1, operand B is loaded inverted and the carry flop is loaded with 1; cin is ignored.
  - The result is a-b; cout=1 means no borrow; ovf is signed subtraction overflow.
  - With sub=0, behaviour is identical to the add-only build.
- Undefined: no sub port; the block is add-only.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse -> busy for 8 cycles, then done pulse with sum=0x96, cout=0, ovf=1.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Same operands with cin=1 -> sum=0x01, cout=1, ovf=0.
- start re-asserted every cycle of RUN with different operands -> ignored; first result 0x96 unchanged. start held in the done cycle -> second operation begins with no gap, and its done arrives 8 cycles later.
- rst asserted 3 cycles into RUN -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0. No done pulse follows until a new start.
- SERIAL_ADDER_SUB_EN defined, WIDTH=8, a=0x10, b=0x20, sub=1, cin=1 -> sum=0xF0, cout=0, ovf=0. With a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
- WIDTH=1: a=1, b=1, cin=1 -> done one cycle after start, sum=1, cout=1, ovf=0.
